// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: byte-serial wide add/sub driving an external 8-bit ripple-carry adder.
module wide_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                overflow,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout
);
    localparam int W  = 8*NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg, b_reg;
    logic          carry;
    logic          last;

    assign last = idx == IW'(NBYTES-1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: state_nxt = start ? RUN : IDLE;
            RUN: begin
                busy      = 1'b1;
                add_a     = a_reg[8*idx +: 8];
                add_b     = b_reg[8*idx +: 8];
                add_cin   = carry;
                state_nxt = last ? DONE : RUN;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // b_reg holds ~op_b in subtract mode, so overflow uses the effective addend sign
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == IDLE && start) begin
            a_reg <= op_a;
            b_reg <= sub ? ~op_b : op_b;
            carry <= sub | cin;
            idx   <= '0;
        end else if (state == RUN) begin
            result[8*idx +: 8] <= add_sum;
            carry              <= add_cout;
            if (last) begin
                carry_out <= add_cout;
                overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[7] != a_reg[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule
